// File: rtl/packet_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : packet_drain_scheduler
// Description : Round-robin drain of SRC_COUNT packet collectors into one
//               valid/ready sink through a small first-word-fall-through FIFO.
//               Each grant is bounded by a timeout. Responses that arrive from
//               a collector without a grant are discarded and counted.
//               Optional statistics counters: define PACKET_DRAIN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_drain_scheduler #(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int SRC_COUNT       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT         = 16,
    localparam int NW = $clog2(NODE_COUNT),
    localparam int IW = PACKET_ID_WIDTH,
    localparam int SW = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    output logic [SRC_COUNT-1:0]      send_signal_o,
    input  logic [SRC_COUNT-1:0]      src_valid_i,
    input  logic [SRC_COUNT*32-1:0]   src_packet_i,
    input  logic [SRC_COUNT*NW-1:0]   src_node_start_i,
    input  logic [SRC_COUNT*NW-1:0]   src_node_dest_i,
    input  logic [SRC_COUNT*IW-1:0]   src_packet_id_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_packet,
    output logic [NW-1:0]             out_node_start,
    output logic [NW-1:0]             out_node_dest,
    output logic [IW-1:0]             out_packet_id,
    output logic [SW-1:0]             out_src,
    output logic                      timeout_pulse,
    output logic [15:0]               drop_count
`ifdef PACKET_DRAIN_STATS_EN
    ,
    output logic [31:0]               grant_count,
    output logic [31:0]               packet_count,
    output logic [31:0]               timeout_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 32 + 2 * NW + IW + SW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_grant;
    logic [SW-1:0]         w_grant_nxt;
    logic [SW-1:0]         r_rr;
    logic [SW-1:0]         w_rr_nxt;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_nxt;
    logic [SRC_COUNT-1:0]  r_send;
    logic [SRC_COUNT-1:0]  w_send_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic [15:0]           r_drop;
    logic [16:0]           w_drop_sum;
    logic [15:0]           w_drop_nxt;

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_free;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic [EW-1:0]         w_head;

    logic                  w_sel_valid;
    logic [EW-1:0]         w_sel_entry;
    logic [SRC_COUNT-1:0]  w_grant_mask;
    logic [SRC_COUNT-1:0]  w_rr_onehot;

    // FIFO status: head is shown directly from storage (first-word fall-through)
    assign out_valid      = (r_count != '0);
    assign w_pop          = out_valid && out_ready;
    assign w_free         = CW'(FIFO_DEPTH) - r_count + {{(CW-1){1'b0}}, w_pop};
    assign w_push         = w_push_req && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
    assign w_head         = r_mem[r_rd_ptr];
    assign out_packet     = w_head[EW-1 -: 32];
    assign out_node_start = w_head[SW+IW+2*NW-1 -: NW];
    assign out_node_dest  = w_head[SW+IW+NW-1 -: NW];
    assign out_packet_id  = w_head[SW+IW-1 -: IW];
    assign out_src        = w_head[SW-1:0];

    assign send_signal_o  = r_send;
    assign timeout_pulse  = r_timeout;
    assign drop_count     = r_drop;

    // Select the granted collector's response and build one-hot masks
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_entry  = '0;
        w_grant_mask = '0;
        w_rr_onehot  = '0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            if (r_grant == SW'(k)) begin
                w_grant_mask[k] = 1'b1;
                w_sel_valid     = src_valid_i[k];
                w_sel_entry     = {src_packet_i[k*32 +: 32],
                                   src_node_start_i[k*NW +: NW],
                                   src_node_dest_i[k*NW +: NW],
                                   src_packet_id_i[k*IW +: IW],
                                   SW'(k)};
            end
            if (r_rr == SW'(k)) begin
                w_rr_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state logic: grant only with two free slots so the trailing response fits
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_nxt      = r_rr;
        w_timer_nxt   = r_timer;
        w_send_nxt    = r_send;
        w_timeout_nxt = 1'b0;
        w_push_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_free >= CW'(2)) begin
                    w_grant_nxt = r_rr;
                    w_send_nxt  = w_rr_onehot;
                    w_timer_nxt = TW'(TIMEOUT - 1);
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end
                if (w_sel_valid) begin
                    w_push_req  = 1'b1;
                    w_send_nxt  = '0;
                    w_state_nxt = S_DRAIN;
                end else if (r_timer == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_send_nxt    = '0;
                    w_state_nxt   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_push_req  = w_sel_valid;
                w_rr_nxt    = (r_grant == SW'(SRC_COUNT - 1)) ? '0 : r_grant + SW'(1);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_send_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Drop accounting: every ungranted valid, plus any push that finds no room
    always_comb begin
        w_drop_sum = {1'b0, r_drop};
        for (int k = 0; k < SRC_COUNT; k++) begin
            if (src_valid_i[k] && !((r_state != S_IDLE) && w_grant_mask[k])) begin
                w_drop_sum = w_drop_sum + 17'd1;
            end
        end
        if (w_push_req && !w_push) begin
            w_drop_sum = w_drop_sum + 17'd1;
        end
        w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Scheduler state register; reset drops the grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_rr      <= '0;
            r_timer   <= '0;
            r_send    <= '0;
            r_timeout <= 1'b0;
            r_drop    <= '0;
        end else if (ce) begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr      <= w_rr_nxt;
            r_timer   <= w_timer_nxt;
            r_send    <= w_send_nxt;
            r_timeout <= w_timeout_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    // Output FIFO storage and pointers; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ce) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sel_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PACKET_DRAIN_STATS_EN
    // Wrapping activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count   <= '0;
            packet_count  <= '0;
            timeout_count <= '0;
        end else if (ce) begin
            if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT)) begin
                grant_count <= grant_count + 32'd1;
            end
            if (w_push) begin
                packet_count <= packet_count + 32'd1;
            end
            if (w_timeout_nxt) begin
                timeout_count <= timeout_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_drain_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_drain_scheduler
// Description : Directed self-checking bench for packet_drain_scheduler with
//               a scoreboard of expected FIFO entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_drain_scheduler;

    localparam int NW  = 3;
    localparam int IW  = 5;
    localparam int SW  = 2;
    localparam int SRC = 4;

    typedef struct packed {
        logic [31:0]   p;
        logic [NW-1:0] s;
        logic [NW-1:0] d;
        logic [IW-1:0] i;
        logic [SW-1:0] src;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce = 1'b1;
    logic [SRC-1:0]    send_signal_o;
    logic [SRC-1:0]    src_valid_i = '0;
    logic [SRC*32-1:0] src_packet_i = '0;
    logic [SRC*NW-1:0] src_node_start_i = '0;
    logic [SRC*NW-1:0] src_node_dest_i = '0;
    logic [SRC*IW-1:0] src_packet_id_i = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_packet;
    logic [NW-1:0]     out_node_start;
    logic [NW-1:0]     out_node_dest;
    logic [IW-1:0]     out_packet_id;
    logic [SW-1:0]     out_src;
    logic              timeout_pulse;
    logic [15:0]       drop_count;
`ifdef PACKET_DRAIN_STATS_EN
    logic [31:0]       grant_count;
    logic [31:0]       packet_count;
    logic [31:0]       timeout_count;
`endif

    int             total = 0;
    int             bad = 0;
    int             seq = 0;
    bit             auto_resp = 1'b0;
    logic [SRC-1:0] last_send = '0;
    ent_t           exp_q[$];

    packet_drain_scheduler #(
        .NODE_COUNT(8), .PACKET_ID_WIDTH(5), .SRC_COUNT(4), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .send_signal_o(send_signal_o), .src_valid_i(src_valid_i),
        .src_packet_i(src_packet_i), .src_node_start_i(src_node_start_i),
        .src_node_dest_i(src_node_dest_i), .src_packet_id_i(src_packet_id_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
        .out_node_start(out_node_start), .out_node_dest(out_node_dest),
        .out_packet_id(out_packet_id), .out_src(out_src),
        .timeout_pulse(timeout_pulse), .drop_count(drop_count)
`ifdef PACKET_DRAIN_STATS_EN
        , .grant_count(grant_count), .packet_count(packet_count), .timeout_count(timeout_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present a response on collector k and record the entry it should become
    task automatic drive_push(input int k, input logic [31:0] p, input logic [NW-1:0] s,
                              input logic [NW-1:0] d, input logic [IW-1:0] i);
        ent_t e;
        src_packet_i[k*32 +: 32]     = p;
        src_node_start_i[k*NW +: NW] = s;
        src_node_dest_i[k*NW +: NW]  = d;
        src_packet_id_i[k*IW +: IW]  = i;
        e.p = p; e.s = s; e.d = d; e.i = i; e.src = SW'(k);
        exp_q.push_back(e);
    endtask

    // Advance to the next falling edge; in auto mode collectors echo send one cycle late
    task automatic step();
        @(negedge clk);
        if (auto_resp) begin
            src_valid_i = last_send;
            for (int k = 0; k < SRC; k++) begin
                if (last_send[k]) begin
                    drive_push(k, {16'hC0DE, 16'(seq)}, NW'(seq), NW'(seq + 1), IW'(seq));
                    seq++;
                end
            end
        end
        last_send = send_signal_o;
    endtask

    task automatic wait_send(input logic [SRC-1:0] expv, input int budget, input string tag);
        for (int n = 0; n < budget && send_signal_o !== expv; n++) step();
        check(tag, send_signal_o, expv);
    endtask

    // Measure one grant that ends in a timeout, optionally freezing ce for 5 cycles
    task automatic measure_grant(input logic [SRC-1:0] expv, input int exp_len,
                                 input bit freeze, input string tag);
        int             n;
        logic [SRC-1:0] g;
        n = 0;
        for (int w = 0; w < 40 && send_signal_o == '0; w++) step();
        g = send_signal_o;
        check({tag, "_who"}, g, expv);
        while (send_signal_o == g && g != '0 && n < 80) begin
            n++;
            if (freeze && n == 4) ce = 1'b0;
            if (freeze && n == 9) ce = 1'b1;
            step();
        end
        check({tag, "_len"}, n, exp_len);
        check({tag, "_tmo"}, timeout_pulse, 1);
        step();
        check({tag, "_tmo_clr"}, timeout_pulse, 0);
    endtask

    // Scoreboard: compare the FIFO head whenever it is about to be popped
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (rst_n && ce && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {out_packet, out_src}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pop_entry", {out_packet, out_node_start, out_node_dest, out_packet_id, out_src}, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int held;
        logic [SRC-1:0] prev;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_send", send_signal_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_drop", drop_count, 0);
        check("rst_out_data", {out_packet, out_node_start, out_node_dest, out_packet_id, out_src}, 0);
        rst_n = 1'b1;

        // Single capture from src 0
        step();
        check("t1_grant_latency", send_signal_o, 4'b0001);
        step();
        drive_push(0, 32'hDEADBEEF, 3'd3, 3'd5, 5'd7);
        src_valid_i = 4'b0001;
        step();
        src_valid_i = '0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_packet", out_packet, 32'hDEADBEEF);
        check("t1_out_src", out_src, 0);
        check("t1_send_dropped", send_signal_o, 0);
        wait_send(4'b0010, 6, "t1_next_grant");
        out_ready = 1'b1;
        step();
        step();
        check("t1_drained", out_valid, 0);

        // Asynchronous reset in the middle of a grant
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_send", send_signal_o, 0);
        step();
        rst_n = 1'b1;

        // Nobody answers: every grant times out, order wraps
        measure_grant(4'b0001, 16, 1'b0, "t2_g0");
        measure_grant(4'b0010, 16, 1'b0, "t2_g1");
        measure_grant(4'b0100, 16, 1'b0, "t2_g2");
        measure_grant(4'b1000, 16, 1'b0, "t2_g3");
        measure_grant(4'b0001, 16, 1'b0, "t2_g0b");
        check("t2_fifo_empty", out_valid, 0);
        measure_grant(4'b0010, 16, 1'b0, "t3_skip1");

        // Granted src 2 answers in GRANT and again in DRAIN
        wait_send(4'b0100, 10, "t3_grant");
        drive_push(2, 32'h22220001, 3'd1, 3'd2, 5'd3);
        src_valid_i = 4'b0100;
        step();
        check("t3_drain_send", send_signal_o, 0);
        drive_push(2, 32'h22220002, 3'd4, 3'd6, 5'd9);
        src_valid_i = 4'b0100;
        step();
        src_valid_i = '0;
        step();
        step();
        check("t3_drop_zero", drop_count, 0);
        check("t3_drained", out_valid, 0);

        // Ungranted responses while src 3 holds the grant
        wait_send(4'b1000, 10, "t4_grant");
        src_valid_i = 4'b0010;
        step();
        check("t4_drop_one", drop_count, 1);
        check("t4_fifo_unchanged", out_valid, 0);
        src_valid_i = 4'b0111;
        step();
        src_valid_i = '0;
        check("t4_drop_popcount", drop_count, 4);
        check("t4_still_granted", send_signal_o, 4'b1000);
        wait_send(4'b0000, 20, "t4_grant_end");

        // Back-pressure: each grant yields two entries, FIFO fills after two grants
        out_ready = 1'b0;
        last_send = send_signal_o;
        auto_resp = 1'b1;
        rises = 0;
        prev = send_signal_o;
        for (int n = 0; n < 40; n++) begin
            step();
            if (send_signal_o != '0 && prev == '0) rises++;
            prev = send_signal_o;
        end
        check("t5_grants_before_full", rises, 2);
        check("t5_idle_send", send_signal_o, 0);
        check("t5_full_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        held = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (send_signal_o != '0) held++;
        end
        check("t5_no_grant_at_3", held, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_send(4'b0100, 6, "t5_resume");
        out_ready = 1'b1;
        repeat (12) step();
        auto_resp = 1'b0;
        src_valid_i = '0;
        wait_send(4'b0000, 30, "t5_quiet");
        repeat (4) step();
        check("t5_drained", out_valid, 0);
        check("t5_drop_stable", drop_count, 4);
        check("t5_sb_empty", exp_q.size(), 0);

        // ce held low for 5 cycles mid-grant stretches the timeout by 5
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        measure_grant(4'b0001, 21, 1'b1, "t6_freeze");

        check("final_sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/packet_drain_scheduler.md
Name: packet_drain_scheduler

Overview:
- Shares one downstream packet sink among SRC_COUNT packet collectors, each of which reassembles 4-byte packets from NoC flits.
- Round-robin: grants one collector at a time by raising that collector's send_signal, captures the completed packet it returns, and queues it in a small output FIFO with a valid/ready output port.
- Sits between the collector array and the result sink (host readout or UART framer).
- A per-grant timeout stops a collector with no complete packet from stalling the scheduler.

Parameters:
- NODE_COUNT, 8, NoC node count; NW = $clog2(NODE_COUNT).
- PACKET_ID_WIDTH, 5, packet id width (IW).
- SRC_COUNT, 4, number of collectors; SW = $clog2(SRC_COUNT), minimum 1.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- TIMEOUT, 16, cycles a grant is held without a response before moving on; at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable. All state, counters and the FIFO freeze when ce=0.
- send_signal_o  out  SRC_COUNT  one-hot grant to the collectors' send_signal inputs.
- src_valid_i  in  SRC_COUNT  collectors' valid_out.
- src_packet_i  in  SRC_COUNT*32  packet_out; source k occupies [32k+31:32k].
- src_node_start_i  in  SRC_COUNT*NW  node_start_out, packed the same way.
- src_node_dest_i  in  SRC_COUNT*NW  node_dest_out, packed the same way.
- src_packet_id_i  in  SRC_COUNT*IW  packet_id_out, packed the same way.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  sink accepts the head.
- out_packet  out  32  head packet.
- out_node_start  out  NW  head source node.
- out_node_dest  out  NW  head destination node.
- out_packet_id  out  IW  head packet id.
- out_src  out  SW  index of the collector that produced the head.
- timeout_pulse  out  1  one-cycle pulse when a grant expires with no response.
- drop_count  out  16  saturating count of discarded responses.

Behaviour:
- Reset values:
  - send_signal_o=0, out_valid=0, timeout_pulse=0, drop_count=0.
  - FIFO empty; rr pointer=0; state=IDLE.
  - out_* data outputs =0.
- All updates below happen only on cycles with ce=1.
- FIFO:
  - Push and pop happen in the same cycle when both are requested.
  - The head is popped when out_valid && out_ready.
  - FWFT: out_* show the head combinationally from storage.
  - free = FIFO_DEPTH - count, computed including a pop in the current cycle.
- IDLE:
  - If free >= 2: grant = rr, assert send_signal_o[rr] next cycle, go to GRANT, load timer = TIMEOUT-1.
  - Two slots are required because a collector's valid_out is registered, so one extra response can arrive after send is dropped.
- GRANT:
  - send_signal_o[grant]=1 and the timer decrements.
  - If src_valid_i[grant]=1: push the entry, drop send_signal_o the next cycle, go to DRAIN.
  - Else if timer==0: timeout_pulse=1 for one cycle, drop send_signal_o, go to DRAIN.
- DRAIN:
  - Lasts exactly one cycle with send_signal_o=0.
  - If src_valid_i[grant]=1, push it; the reserved slot guarantees room.
  - Then rr = (grant+1) mod SRC_COUNT and go to IDLE.
- Non-granted responses: a src_valid_i[k]=1 with k != grant, or any valid seen in IDLE, is discarded and increments drop_count.
  - drop_count saturates at 16'hFFFF.
  - Several simultaneous drops in one cycle add popcount(ungranted valids).
- A push with no free slot cannot occur by construction; if it does, the entry is discarded and counted in drop_count.
- Pointer wrap: rr wraps from SRC_COUNT-1 to 0. Non-power-of-two SRC_COUNT must work.
- Grant latency: IDLE to send asserted is 1 cycle. The minimum time per grant is 3 cycles: IDLE, GRANT, DRAIN.
- Reset mid-grant: send_signal_o drops asynchronously and the FIFO contents are lost.
- ce=0 mid-GRANT: send_signal_o holds its value and the timer does not count.

Optional Feature:
- Macro: PACKET_DRAIN_STATS_EN.
- When defined, adds ports:
  - grant_count, out 32: grants issued.
  - packet_count, out 32: entries pushed.
  - timeout_count, out 32: timeouts.
  - All three are wrapping counters, reset to 0, and update only when ce=1.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, src 0 answers 1 cycle after grant with packet 32'hDEADBEEF, start=3, dest=5, id=7 -> out_valid rises; out_packet=DEADBEEF, out_src=0; the next grant goes to src 1.
- No source ever answers, TIMEOUT=16 -> each grant lasts 16 cycles, then timeout_pulse fires; grant order is 0,1,2,3,0; FIFO stays empty.
- Granted src 2 pulses valid in GRANT and again in DRAIN -> both entries appear in order; drop_count=0.
- src 1 pulses valid while src 3 is granted -> the entry is discarded and drop_count=1; the FIFO is unchanged.
- out_ready held 0 while every source answers -> after 2 captures with FIFO_DEPTH=4 the scheduler stays in IDLE with no grants. Then out_ready=1 for 1 cycle -> count=3, no grant yet; one more pop -> granting resumes.
- Assert ce=0 for 5 cycles mid-GRANT -> the timer and send_signal_o are frozen; the timeout fires 5 cycles later than it would otherwise.
